// File: rtl/neural_net_loader_if.sv
// Sample-stream, network and result-handshake signals of the sonar sample loader.
interface neural_net_loader_if #(
  parameter int unsigned N_FEAT = 60,
  parameter int unsigned W      = 16
);
  logic [W-1:0]        ulaz_podatak;
  logic                ulaz_valid;
  logic                ulaz_ready;
  logic [N_FEAT*W-1:0] uzorak;
  logic [W-1:0]        izlaz_1;
  logic [W-1:0]        izlaz_2;
  logic                rez_valid;
  logic                rez_ready;
  logic [W-1:0]        rez_1;
  logic [W-1:0]        rez_2;
  logic                mina;
  logic                zauzet;

  // Feature source, network stub and result consumer
  modport master (
    output ulaz_podatak, ulaz_valid, izlaz_1, izlaz_2, rez_ready,
    input  ulaz_ready, uzorak, rez_valid, rez_1, rez_2, mina, zauzet
  );

  // The loader itself
  modport slave (
    input  ulaz_podatak, ulaz_valid, izlaz_1, izlaz_2, rez_ready,
    output ulaz_ready, uzorak, rez_valid, rez_1, rez_2, mina, zauzet
  );
endinterface

// File: rtl/neural_net_loader.sv
// Assembles a 60-feature sonar sample for Neural_net, waits for the network
// to settle, then captures and presents its two outputs with a mine/rock flag.
module neural_net_loader #(
  parameter int unsigned N_FEAT = 60,
  parameter int unsigned W      = 16,
  parameter int unsigned SETTLE = 4
) (
  input  logic                clk,
  input  logic                rst,
  neural_net_loader_if.slave  bus
);
  localparam int unsigned UZ_W = N_FEAT * W;
  localparam int unsigned FC_W = $clog2(N_FEAT);
  localparam int unsigned SC_W = 4;

  typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_HOLD} state_t;

  state_t          state;
  logic [FC_W-1:0] feat_cnt;
  logic [SC_W-1:0] settle_cnt;
  logic [UZ_W-1:0] uzorak_q;
  logic [W-1:0]    rez_1_q;
  logic [W-1:0]    rez_2_q;
  logic            mina_q;
  logic            rez_valid_q;

  // Handshake readiness and busy flag decode only state and reset
  assign bus.ulaz_ready = (state == S_LOAD) && !rst;
  assign bus.zauzet     = (state != S_LOAD) && !rst;

  assign bus.uzorak    = uzorak_q;
  assign bus.rez_1     = rez_1_q;
  assign bus.rez_2     = rez_2_q;
  assign bus.mina      = mina_q;
  assign bus.rez_valid = rez_valid_q;

  // Load / settle / hold sequencing with all datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_LOAD;
      feat_cnt    <= '0;
      settle_cnt  <= '0;
      uzorak_q    <= '0;
      rez_1_q     <= '0;
      rez_2_q     <= '0;
      mina_q      <= 1'b0;
      rez_valid_q <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (bus.ulaz_valid) begin
            // Newest feature enters at the bottom; feature 0 ends at the top
            uzorak_q <= {uzorak_q[UZ_W-W-1:0], bus.ulaz_podatak};
            if (feat_cnt == FC_W'(N_FEAT - 1)) begin
              feat_cnt   <= '0;
              settle_cnt <= SC_W'(SETTLE - 1);
              state      <= S_SETTLE;
            end else begin
              feat_cnt <= feat_cnt + FC_W'(1);
            end
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            rez_1_q     <= bus.izlaz_1;
            rez_2_q     <= bus.izlaz_2;
            mina_q      <= (bus.izlaz_1 > bus.izlaz_2);
            rez_valid_q <= 1'b1;
            state       <= S_HOLD;
          end else begin
            settle_cnt <= settle_cnt - SC_W'(1);
          end
        end
        S_HOLD: begin
          if (bus.rez_ready) begin
            rez_valid_q <= 1'b0;
            state       <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule
